serial_add: RTL and testbench
=============================

SERIAL_ADD -- requirements
Module: serial_add

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to add a and b; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: operand A; sampled on the edge that accepts start.
REQ-006 The block SHALL have port b, input, WIDTH bits: operand B; sampled with a.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in, present only when SERIAL_ADD_CIN_EN is defined.
REQ-008 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a completed result.
REQ-010 The block SHALL have port sum, output, WIDTH bits: registered result, (a+b+carry-in) mod 2^WIDTH.
REQ-011 The block SHALL have port cout, output, 1 bit: registered carry out of bit WIDTH-1.

Function
REQ-012 The block SHALL implement a two-state FSM: IDLE and RUN.
REQ-013 In IDLE, start=1 at a rising edge SHALL load a and b into shift registers, load the carry flop with the carry-in, clear the bit counter, and go to RUN.
REQ-014 In RUN, each edge SHALL process one bit LSB-first with full-adder logic: sum bit = a0^b0^c, carry = a0&b0 | a0&c | b0&c; both operand registers shift right one place; the sum bit shifts into the MSB of the result shift register.
REQ-015 On the edge that processes bit WIDTH-1, the FSM SHALL return to IDLE, update sum with the full result and cout with the final carry, and assert done.
REQ-016 Latency: if start is accepted at edge k, sum, cout and done SHALL be valid after edge k+WIDTH, with busy high from edge k to edge k+WIDTH.
REQ-017 done SHALL be high for exactly one clock cycle per completed operation.
REQ-018 start SHALL be ignored while in RUN; a and b changes during RUN SHALL NOT affect the result.
REQ-019 start high in the cycle in which done is high SHALL be accepted; back-to-back operations take WIDTH+1 cycles each with no dead cycle.
REQ-020 sum and cout SHALL hold their last value until the next completion; partial results SHALL never appear on sum.
REQ-021 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-022 rst_n low SHALL immediately force IDLE, busy=0, done=0, sum=0, cout=0, carry flop=0, counter=0, operand registers=0.
REQ-023 Reset asserted mid-RUN SHALL abort the operation with no done pulse; after release the block SHALL accept start on the first edge.

Configuration
REQ-024 The macro SERIAL_ADD_CIN_EN SHALL control the carry-in feature.
REQ-025 With SERIAL_ADD_CIN_EN defined, port cin SHALL exist and be sampled with a and b as the initial carry.
REQ-026 Without SERIAL_ADD_CIN_EN, port cin SHALL be absent and the initial carry SHALL be 0.

Verification (WIDTH=8)
REQ-027 The bench SHALL cover: a=0x5A, b=0x3C, start at edge 0 -> busy high for 8 cycles; after edge 8, sum=0x96, cout=0, done=1 for 1 cycle.
REQ-028 The bench SHALL cover: a=0xFF, b=0x01 -> sum=0x00, cout=1; start=1 held throughout RUN causes no restart, and a second operation is accepted in the done cycle.
REQ-029 The bench SHALL cover: start accepted, then rst_n low at edge 4 -> all outputs 0 immediately, no done pulse; a new 0x01+0x02 afterwards -> sum=0x03, cout=0.
REQ-030 The bench SHALL cover: a=0x80, b=0x80 followed back-to-back by a=0x7F, b=0x01 -> 0x00/cout=1, then 0x80/cout=0, with done pulses exactly 9 cycles apart.
REQ-031 The bench SHALL cover, with SERIAL_ADD_CIN_EN defined: a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1; without the macro: a=0xFF, b=0x00 -> sum=0xFF, cout=0.
REQ-032 The bench SHALL cover a random check of 1000 operand pairs against a+b(+cin) reference.

Source files
------------

// File: rtl/serial_add.sv
// Bit-serial adder: one full-adder step per clock, LSB first.
// Optional carry-in port enabled by defining SERIAL_ADD_CIN_EN.
module serial_add #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_CIN_EN
  input  logic             cin,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;

  logic             c_init;
  logic             s_bit;
  logic             c_nxt;

`ifdef SERIAL_ADD_CIN_EN
  assign c_init = cin;
`else
  assign c_init = 1'b0;
`endif

  assign s_bit = a_q[0] ^ b_q[0] ^ c_q;
  assign c_nxt = (a_q[0] & b_q[0]) |
                 (a_q[0] & c_q) |
                 (b_q[0] & c_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          c_d     = c_init;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        acc_d = {s_bit, acc_q[WIDTH-1:1]};
        c_d   = c_nxt;
        // Counter holds at the last bit so it never wraps.
        if (cnt_q == LAST) begin
          state_d = IDLE;
          sum_d   = {s_bit, acc_q[WIDTH-1:1]};
          cout_d  = c_nxt;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add.sv
// Directed and random bench for serial_add at WIDTH=8.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_serial_add;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         cin_i;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_chk;
  int n_pass;

  serial_add #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a_i),
    .b     (b_i),
`ifdef SERIAL_ADD_CIN_EN
    .cin   (cin_i),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done; returns edges elapsed (0 on timeout).
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done) begin
        n = i;
        break;
      end
    end
    if (n == 0) chk("done_timeout", 0, 1);
  endtask

  task automatic run_op(input string tag,
                        input logic [W-1:0] av,
                        input logic [W-1:0] bv,
                        input logic ci,
                        input logic [W:0] exp);
    int n;
    a_i   = av;
    b_i   = bv;
    cin_i = ci;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    chk({tag, "_lat"}, n, W);
    chk({tag, "_res"}, {cout, sum}, exp);
  endtask

  initial begin
    int n;
    logic [W-1:0] ra, rb;
    logic         rc;
    logic         cin_on;
    n_chk  = 0;
    n_pass = 0;
`ifdef SERIAL_ADD_CIN_EN
    cin_on = 1'b1;
`else
    cin_on = 1'b0;
`endif
    rst_n = 1'b0;
    start = 1'b0;
    a_i   = '0;
    b_i   = '0;
    cin_i = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    #2 rst_n = 1'b1;
    tick();

    // 0x5A + 0x3C: busy for 8 cycles, done for 1
    a_i   = 8'h5A;
    b_i   = 8'h3C;
    start = 1'b1;
    tick();
    start = 1'b0;
    a_i   = 8'hFF;
    b_i   = 8'hFF;
    chk("t1_busy0", busy, 1);
    for (int i = 1; i < W; i++) begin
      tick();
      chk("t1_busy", busy, 1);
      chk("t1_nodone", done, 0);
      chk("t1_sumhold", sum, 0);
    end
    tick();
    chk("t1_done", done, 1);
    chk("t1_busyoff", busy, 0);
    chk("t1_sum", sum, 8'h96);
    chk("t1_cout", cout, 0);
    tick();
    chk("t1_pulse", done, 0);
    chk("t1_sumkeep", sum, 8'h96);

    // 0xFF + 0x01 with start held high through RUN
    a_i   = 8'hFF;
    b_i   = 8'h01;
    start = 1'b1;
    tick();
    a_i = 8'h10;
    b_i = 8'h20;
    wait_done(n);
    chk("t2_norestart", n, W);
    chk("t2_sum", sum, 8'h00);
    chk("t2_cout", cout, 1);
    tick();
    start = 1'b0;
    chk("t2_accept", busy, 1);
    chk("t2_hold", {cout, sum}, 9'h100);
    wait_done(n);
    chk("t2_lat2", n, W);
    chk("t2_sum2", {cout, sum}, 9'h030);

    // reset in the middle of an operation
    a_i   = 8'h33;
    b_i   = 8'h44;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("t3_busy", busy, 0);
    chk("t3_sum", sum, 0);
    chk("t3_cout", cout, 0);
    chk("t3_done", done, 0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) n++;
    end
    chk("t3_nodone", n, 0);
    rst_n = 1'b1;
    run_op("t3_new", 8'h01, 8'h02, 1'b0, 9'h003);

    // back-to-back: done pulses 9 cycles apart
    a_i   = 8'h80;
    b_i   = 8'h80;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    chk("t4_res1", {cout, sum}, 9'h100);
    a_i   = 8'h7F;
    b_i   = 8'h01;
    start = 1'b1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      start = 1'b0;
      if (done) begin
        n = i;
        break;
      end
    end
    chk("t4_gap", n, W + 1);
    chk("t4_res2", {cout, sum}, 9'h080);

    // carry-in boundary
    if (cin_on) run_op("t5_cin", 8'hFF, 8'h00, 1'b1, 9'h100);
    else run_op("t5_nocin", 8'hFF, 8'h00, 1'b1, 9'h0FF);

    // random operand pairs
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      run_op("rnd", ra, rb, rc,
             {1'b0, ra} + {1'b0, rb} + {8'b0, rc & cin_on});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
